psram_qspi_ctrl: RTL and testbench



---
 rtl/psram_qspi_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_psram_qspi_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qspi_ctrl.sv
// PSRAM QSPI sequencer: start-up delay, SPI->QSPI switch, then single-byte read/write over SIO.
// Optional macro PSRAM_RESET_SEQ_EN adds the 0x66/0x99 software reset frames to the init chain.
module psram_qspi_ctrl #(
  parameter int STARTUP_TIME = 4055,
  parameter int WAIT_CYCLES  = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_done,
  output logic        ready,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        psram_cs_n,
  output logic        psram_sclk,
  output logic [3:0]  psram_sio_o,
  output logic        psram_sio_oe,
  input  logic [3:0]  psram_sio_i
);

  typedef enum logic [3:0] {
    S_STARTUP,
`ifdef PSRAM_RESET_SEQ_EN
    S_RST_EN,
    S_RST,
`endif
    S_QPI_EN,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_WDATA,
    S_RDATA,
    S_DESEL
  } state_t;

  localparam logic [11:0] LP_START_LAST = 12'(STARTUP_TIME - 1);
  localparam logic [7:0]  LP_WAIT_LAST  = 8'(WAIT_CYCLES - 1);

  state_t      r_state, w_next, r_ret;
  logic [11:0] r_start_cnt;
  logic [7:0]  r_cnt;
  logic        r_phase;
  logic [7:0]  r_byte;
  logic [7:0]  r_wdata;
  logic [23:0] r_addr;
  logic        r_we;
  logic [3:0]  r_rd_hi;
  logic [7:0]  r_rdata;
  logic        r_rvalid;
  logic        r_init_done;

  logic        w_cs_n;
  logic        w_sclk;
  logic        w_oe;
  logic [3:0]  w_sio;

  // Frame states advance only on the edge closing phase B of their last bit/nibble.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_STARTUP: if (r_start_cnt == LP_START_LAST) begin
`ifdef PSRAM_RESET_SEQ_EN
        w_next = S_RST_EN;
`else
        w_next = S_QPI_EN;
`endif
      end
`ifdef PSRAM_RESET_SEQ_EN
      S_RST_EN,
      S_RST,
`endif
      S_QPI_EN:  if (r_phase && r_cnt == 8'd7) w_next = S_DESEL;
      S_IDLE:    if (req) w_next = S_CMD;
      S_CMD:     if (r_phase && r_cnt == 8'd1) w_next = S_ADDR;
      S_ADDR:    if (r_phase && r_cnt == 8'd5)
                   w_next = r_we ? S_WDATA : ((WAIT_CYCLES == 0) ? S_RDATA : S_WAIT);
      S_WAIT:    if (r_phase && r_cnt == LP_WAIT_LAST) w_next = S_RDATA;
      S_WDATA,
      S_RDATA:   if (r_phase && r_cnt == 8'd1) w_next = S_DESEL;
      S_DESEL:   if (r_cnt == 8'd1) w_next = r_ret;
      default:   w_next = S_STARTUP;
    endcase
  end

  always_comb begin
    w_cs_n = 1'b1;
    w_sclk = 1'b0;
    w_oe   = 1'b0;
    w_sio  = 4'h0;
    case (r_state)
`ifdef PSRAM_RESET_SEQ_EN
      S_RST_EN,
      S_RST,
`endif
      S_QPI_EN: begin
        w_cs_n = 1'b0;
        w_sclk = r_phase;
        w_oe   = 1'b1;
        w_sio  = {3'b000, r_byte[7]};
      end
      S_CMD,
      S_WDATA: begin
        w_cs_n = 1'b0;
        w_sclk = r_phase;
        w_oe   = 1'b1;
        w_sio  = r_byte[7:4];
      end
      S_ADDR: begin
        w_cs_n = 1'b0;
        w_sclk = r_phase;
        w_oe   = 1'b1;
        w_sio  = r_addr[23:20];
      end
      S_WAIT,
      S_RDATA: begin
        w_cs_n = 1'b0;
        w_sclk = r_phase;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_STARTUP;
      r_ret       <= S_IDLE;
      r_start_cnt <= 12'd0;
      r_cnt       <= 8'd0;
      r_phase     <= 1'b0;
      r_byte      <= 8'h00;
      r_wdata     <= 8'h00;
      r_addr      <= 24'h0;
      r_we        <= 1'b0;
      r_rd_hi     <= 4'h0;
      r_rdata     <= 8'h00;
      r_rvalid    <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= 1'b0;
      if (r_state == S_STARTUP) r_start_cnt <= r_start_cnt + 12'd1;

      if (w_next != r_state) begin
        r_phase <= 1'b0;
        r_cnt   <= 8'd0;
      end else if (r_state == S_DESEL) begin
        r_cnt <= r_cnt + 8'd1;
      end else if (!w_cs_n) begin
        r_phase <= ~r_phase;
        if (r_phase) r_cnt <= r_cnt + 8'd1;
      end

      // Shift out / sample in at the edge that closes phase B.
      if (r_phase && !w_cs_n) begin
        case (r_state)
`ifdef PSRAM_RESET_SEQ_EN
          S_RST_EN,
          S_RST,
`endif
          S_QPI_EN: r_byte <= {r_byte[6:0], 1'b0};
          S_CMD,
          S_WDATA:  r_byte <= {r_byte[3:0], 4'h0};
          S_ADDR:   r_addr <= {r_addr[19:0], 4'h0};
          S_RDATA: begin
            if (r_cnt == 8'd0) begin
              r_rd_hi <= psram_sio_i;
            end else begin
              r_rdata  <= {r_rd_hi, psram_sio_i};
              r_rvalid <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // State-entry loads come last so they override the shift above.
      if (w_next != r_state) begin
        case (w_next)
`ifdef PSRAM_RESET_SEQ_EN
          S_RST_EN: r_byte <= 8'h66;
          S_RST:    r_byte <= 8'h99;
`endif
          S_QPI_EN: r_byte <= 8'h35;
          S_CMD: begin
            r_byte  <= we ? 8'h38 : 8'hEB;
            r_we    <= we;
            r_addr  <= {1'b0, addr};
            r_wdata <= wdata;
          end
          S_WDATA:  r_byte <= r_wdata;
          S_DESEL: begin
            r_ret <= S_IDLE;
`ifdef PSRAM_RESET_SEQ_EN
            if (r_state == S_RST_EN) r_ret <= S_RST;
            if (r_state == S_RST)    r_ret <= S_QPI_EN;
`endif
          end
          default: ;
        endcase
      end

      if (r_state == S_DESEL && w_next == S_IDLE) r_init_done <= 1'b1;
    end
  end

  assign init_done    = r_init_done;
  assign ready        = (r_state == S_IDLE);
  assign rdata        = r_rdata;
  assign rvalid       = r_rvalid;
  assign psram_cs_n   = w_cs_n;
  assign psram_sclk   = w_sclk;
  assign psram_sio_o  = w_sio;
  assign psram_sio_oe = w_oe;

endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Bench for psram_qspi_ctrl: cycle-indexed waveform model from the frame rules, plus directed literal checks.
`timescale 1ns/1ps
module tb_psram_qspi_ctrl;
  localparam int ST = 16;
  localparam int WC = 6;
`ifdef PSRAM_RESET_SEQ_EN
  localparam int NF = 3;
  localparam int INIT_DONE_AT = 70;
`else
  localparam int NF = 1;
  localparam int INIT_DONE_AT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [22:0] addr;
  logic [7:0]  wdata;
  logic        init_done, ready, rvalid;
  logic [7:0]  rdata;
  logic        psram_cs_n, psram_sclk, psram_sio_oe;
  logic [3:0]  psram_sio_o;
  logic [3:0]  psram_sio_i = 4'h0;

  always #5 clk = ~clk;

  psram_qspi_ctrl #(.STARTUP_TIME(ST), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .ready(ready), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .psram_cs_n(psram_cs_n),
    .psram_sclk(psram_sclk), .psram_sio_o(psram_sio_o), .psram_sio_oe(psram_sio_oe),
    .psram_sio_i(psram_sio_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: t = clk cycles since reset release; tx_* = last accepted request
  bit         armed = 0;
  int         t = 0;
  bit         tx_valid = 0;
  int         tx_t = 0;
  int         tx_L = 0;
  bit         tx_we = 0;
  logic [3:0] tx_nib [16];
  logic [7:0] tx_rbyte = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] psram_byte = 8'h00;
  bit         e_csn, e_sclk, e_oe, e_ready, e_init, e_rvalid;
  logic [3:0] e_sio;

  logic [3:0] nibq [$];
  int         cs_falls = 0;

  function automatic logic [7:0] init_byte(int j);
`ifdef PSRAM_RESET_SEQ_EN
    if (j == 0) return 8'h66;
    if (j == 1) return 8'h99;
`endif
    return 8'h35;
  endfunction

  function automatic void calc();
    int j, r, k, n;
    logic [7:0] b;
    e_csn = 1; e_sclk = 0; e_oe = 0; e_sio = 4'h0; e_rvalid = 0;
    e_init  = (t >= ST + 18 * NF);
    e_ready = e_init;
    if (t >= ST && t < ST + 18 * NF) begin
      j = (t - ST) / 18;
      r = (t - ST) % 18;
      if (r < 16) begin
        b = init_byte(j);
        e_csn = 0; e_sclk = (r % 2 == 1); e_oe = 1;
        e_sio = {3'b000, b[7 - r / 2]};
      end
    end
    if (e_init && tx_valid && t > tx_t && t <= tx_t + tx_L + 2) begin
      e_ready = 0;
      k = t - tx_t;
      if (k <= tx_L) begin
        n = (k - 1) / 2;
        e_csn = 0; e_sclk = ((k - 1) % 2 == 1);
        if (tx_we || n < 8) begin
          e_oe = 1; e_sio = tx_nib[n];
        end
      end else if (k == tx_L + 1 && !tx_we) begin
        e_rvalid = 1;
      end
    end
  endfunction

  // model update on each active edge
  initial forever begin
    @(posedge clk);
    if (rst) begin
      armed = 1; t = 0; tx_valid = 0; exp_rdata = 8'h00;
    end else if (armed) begin
      if (tx_valid && !tx_we && t == tx_t + tx_L) exp_rdata = tx_rbyte;
      if (e_ready && req) begin
        logic [7:0]  cmd;
        logic [23:0] a24;
        cmd = we ? 8'h38 : 8'hEB;
        a24 = {1'b0, addr};
        tx_valid = 1; tx_t = t; tx_we = we; tx_rbyte = psram_byte;
        tx_L = we ? 20 : 2 * (10 + WC);
        for (int i = 0; i < 16; i++) tx_nib[i] = 4'h0;
        tx_nib[0] = cmd[7:4];
        tx_nib[1] = cmd[3:0];
        for (int i = 0; i < 6; i++) tx_nib[2 + i] = a24[23 - 4 * i -: 4];
        if (we) begin
          tx_nib[8] = wdata[7:4];
          tx_nib[9] = wdata[3:0];
        end
      end
      t++;
    end
  end

  // per-cycle compare, and PSRAM read-data drive for the current cycle
  initial forever begin
    @(negedge clk);
    if (armed) begin
      int k, n;
      calc();
      psram_sio_i = 4'($urandom);
      if (tx_valid && !tx_we && t > tx_t && t <= tx_t + tx_L) begin
        k = t - tx_t;
        n = (k - 1) / 2;
        if (n == 8 + WC) psram_sio_i = tx_rbyte[7:4];
        if (n == 9 + WC) psram_sio_i = tx_rbyte[3:0];
      end
      n_tests++;
      if (psram_cs_n !== e_csn || psram_sclk !== e_sclk || psram_sio_oe !== e_oe ||
          (e_oe && psram_sio_o !== e_sio) || (t == 0 && psram_sio_o !== 4'h0) ||
          ready !== e_ready || init_done !== e_init || rvalid !== e_rvalid || rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL cycle t=%0d: got cs_n=%b sclk=%b oe=%b sio=%h ready=%b init=%b rvalid=%b rdata=%h; need cs_n=%b sclk=%b oe=%b sio=%h ready=%b init=%b rvalid=%b rdata=%h",
                 t, psram_cs_n, psram_sclk, psram_sio_oe, psram_sio_o, ready, init_done, rvalid, rdata,
                 e_csn, e_sclk, e_oe, e_sio, e_ready, e_init, e_rvalid, exp_rdata);
      end
    end
  end

  initial forever begin
    @(posedge psram_sclk);
    if (psram_cs_n === 1'b0 && psram_sio_oe === 1'b1) nibq.push_back(psram_sio_o);
  end

  initial forever begin
    @(negedge psram_cs_n);
    cs_falls++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h need %0h", name, act, exp);
    end
  endtask

  task automatic check_init();
    int tc = -1, td = -1;
    for (int i = 0; i < 200 && tc < 0; i++) begin
      @(negedge clk);
      if (psram_cs_n === 1'b0) tc = t;
    end
    chk("first cs_n fall cycle", tc, ST);
    for (int i = 0; i < 200 && td < 0; i++) begin
      if (init_done === 1'b1) td = t;
      else @(negedge clk);
    end
    chk("init_done cycle", td, INIT_DONE_AT);
    chk("init bit count", nibq.size(), 8 * NF);
    if (nibq.size() == 8 * NF)
      for (int j = 0; j < NF; j++) begin
        logic [7:0] b;
        b = init_byte(j);
        for (int i = 0; i < 8; i++) chk("init frame bit", int'(nibq[8 * j + i]), int'(b[7 - i]));
      end
  endtask

  task automatic issue(input bit w, input logic [22:0] a, input logic [7:0] d, output int tacc);
    int lim = 0;
    @(negedge clk);
    while (ready !== 1'b1 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 200) chk("ready timeout before request", 0, 1);
    req = 1; we = w; addr = a; wdata = d; tacc = t;
    @(negedge clk);
    req = 0;
  endtask

  task automatic wait_ready(input int tacc, output int lat);
    int lim = 0;
    while (ready !== 1'b1 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    lat = (lim >= 200) ? -1 : t - tacc;
  endtask

  initial begin
    int T, lat;
    logic [3:0] wexp [10];
    logic [3:0] rexp [8];
    wexp = '{4'h3, 4'h8, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'h5};
    rexp = '{4'hE, 4'hB, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    rst = 1; req = 0; we = 0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    nibq.delete();
    rst = 0;
    check_init();

    // directed write
    nibq.delete();
    issue(1'b1, 23'h012345, 8'hA5, T);
    wait_ready(T, lat);
    chk("write ready latency", lat, 23);
    chk("write nibble count", nibq.size(), 10);
    if (nibq.size() == 10) for (int i = 0; i < 10; i++) chk("write nibble", int'(nibq[i]), int'(wexp[i]));

    // directed read at top address
    nibq.delete();
    psram_byte = 8'h3C;
    issue(1'b0, 23'h7FFFFF, 8'h00, T);
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      if (rvalid === 1'b1) lat = t - T;
      else @(negedge clk);
    end
    chk("rvalid latency", lat, 33);
    chk("read rdata", int'(rdata), 8'h3C);
    @(negedge clk);
    chk("rvalid single pulse", int'(rvalid), 0);
    wait_ready(T, lat);
    chk("read ready latency", lat, 35);
    chk("read driven nibble count", nibq.size(), 8);
    if (nibq.size() == 8) for (int i = 0; i < 8; i++) chk("read nibble", int'(nibq[i]), int'(rexp[i]));

    // request while busy is dropped
    cs_falls = 0;
    psram_byte = 8'($urandom);
    issue(1'b0, 23'($urandom), 8'h00, T);
    repeat (5) @(negedge clk);
    req = 1; we = 1; addr = 23'($urandom);
    @(negedge clk);
    req = 0;
    wait_ready(T, lat);
    repeat (10) @(negedge clk);
    chk("transactions while busy", cs_falls, 1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      logic [22:0] a;
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 23'h7FFFFF : (sel == 1) ? 23'h000000 : 23'($urandom);
      psram_byte = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom), a, 8'($urandom), T);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        req = 1; we = 1'($urandom); addr = 23'($urandom);
        @(negedge clk);
        req = 0;
      end
    end
    wait_ready(T, lat);

    // reset in the 5th nibble of a write
    issue(1'b1, 23'($urandom), 8'($urandom), T);
    for (int i = 0; i < 50 && t != T + 9; i++) @(negedge clk);
    chk("reached 5th nibble", t, T + 9);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort cs_n", int'(psram_cs_n), 1);
    chk("abort oe", int'(psram_sio_oe), 0);
    chk("abort init_done", int'(init_done), 0);
    chk("abort ready", int'(ready), 0);
    nibq.delete();
    check_init();

    // reset and request in the same cycle: reset wins
    issue(1'b1, 23'h000001, 8'h11, T);
    wait_ready(T, lat);
    @(negedge clk);
    rst = 1; req = 1; we = 1; addr = 23'h0ABCDE;
    @(negedge clk);
    rst = 0; req = 0;
    nibq.delete();
    check_init();
    psram_byte = 8'hC3;
    issue(1'b0, 23'h0ABCDE, 8'h00, T);
    wait_ready(T, lat);
    chk("final read ready latency", lat, 35);
    chk("final read rdata", int'(rdata), 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
